controle_multiciclo: RTL and testbench

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo.sv | 64 ++++++
 tb/tb_controle_multiciclo.sv | 97 +++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM (IDLE/READ/EXEC/MEM/WB) for a LOAD/STORE/ADD/SUB datapath.
// Ports: clk, rst_n (sync, active low); instr/instr_valid/instr_ready handshake;
// done retire pulse; reg_we/reg_rw/reg_ra/reg_rb register-file controls;
// mem_we, sinal, sel_mux1, sel_mux2 datapath controls; const_c zero-extended
// immediate; retired count of completed instructions.
module controle_multiciclo #(
  parameter int DATA_W = 64,
  parameter int IMM_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              done,
  output logic              reg_we,
  output logic [4:0]        reg_rw,
  output logic [4:0]        reg_ra,
  output logic [4:0]        reg_rb,
  output logic              mem_we,
  output logic              sinal,
  output logic              sel_mux1,
  output logic              sel_mux2,
  output logic [DATA_W-1:0] const_c,
  output logic [31:0]       retired
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] EXEC = 3'd2;
  localparam logic [2:0] MEM  = 3'd3;
  localparam logic [2:0] WB   = 3'd4;
  logic [2:0]  state, next;
  logic [31:0] ir;
  logic        alu, store;
  assign alu   = ir[31];
  assign store = ir[31:30] == 2'b01;
  always_comb
    next = state == IDLE ? (instr_valid ? READ : IDLE) :
           state == READ ? EXEC :
           state == EXEC ? (alu ? WB : MEM) :
           state == MEM  ? (store ? IDLE : WB) : IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= IDLE;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= next;
      if (state == IDLE && instr_valid) ir <= instr;
      if (done) retired <= retired + 32'd1;
    end
  assign instr_ready = state == IDLE;
  assign done        = state == WB || (state == MEM && store);
  assign reg_we      = state == WB && ir[29:25] != 5'd0;
  assign mem_we      = state == MEM && store;
  // ALU selections are set in EXEC and held through WB; memory ops keep them at 0
  assign sel_mux1    = alu && (state == EXEC || state == WB);
  assign sinal       = sel_mux1 && ir[30];
  assign sel_mux2    = state == WB && alu;
  assign reg_rw      = ir[29:25];
  assign reg_ra      = ir[24:20];
  assign reg_rb      = ir[19:15];
  assign const_c     = DATA_W'(ir[IMM_W-1:0]);
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: randomized and directed checks of controle_multiciclo against a schedule-based model.
module tb_controle_multiciclo;
  logic        clk = 1'b0;
  logic        rst_n, instr_valid, instr_ready, done, reg_we, mem_we, sinal, sel_mux1, sel_mux2;
  logic [31:0] instr, retired;
  logic [4:0]  reg_rw, reg_ra, reg_rb;
  logic [63:0] const_c;
  int          checks = 0, errors = 0;
  logic        m_busy;
  int          m_cyc;
  logic [1:0]  m_op;
  logic [4:0]  m_rd, m_ra, m_rb;
  logic [14:0] m_imm;
  logic [31:0] m_ret;
  controle_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .reg_we(reg_we), .reg_rw(reg_rw),
    .reg_ra(reg_ra), .reg_rb(reg_rb), .mem_we(mem_we), .sinal(sinal),
    .sel_mux1(sel_mux1), .sel_mux2(sel_mux2), .const_c(const_c), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int len(input logic [1:0] op);
    return op == 2'b00 ? 4 : 3;
  endfunction
  function automatic logic [31:0] mk(input logic [1:0] op, input int rd, input int ra, input int rb, input int imm);
    return {op, 5'(rd), 5'(ra), 5'(rb), 15'(imm)};
  endfunction
  task automatic model_reset();
    m_busy = 1'b0; m_cyc = 0; m_op = '0; m_rd = '0; m_ra = '0; m_rb = '0; m_imm = '0; m_ret = '0;
  endtask
  task automatic cycle(input logic r, input logic v, input logic [31:0] i);
    logic fin, is_alu;
    rst_n = r; instr_valid = v; instr = i;
    @(negedge clk);
    fin    = m_busy && m_cyc == len(m_op);
    is_alu = m_op[1];
    chk("instr_ready", instr_ready, !m_busy);
    chk("done", done, fin);
    chk("reg_we", reg_we, fin && m_op != 2'b01 && m_rd != 5'd0);
    chk("mem_we", mem_we, fin && m_op == 2'b01);
    chk("sel_mux1", sel_mux1, m_busy && m_cyc >= 2 && is_alu);
    chk("sinal", sinal, m_busy && m_cyc >= 2 && m_op == 2'b11);
    chk("sel_mux2", sel_mux2, fin && is_alu);
    chk("reg_rw", reg_rw, m_rd);
    chk("reg_ra", reg_ra, m_ra);
    chk("reg_rb", reg_rb, m_rb);
    chk("const_c", const_c, {49'd0, m_imm});
    chk("retired", retired, m_ret);
    @(posedge clk);
    if (!r) model_reset();
    else if (!m_busy) begin
      if (v) begin
        m_busy = 1'b1; m_cyc = 1; m_op = i[31:30];
        m_rd = i[29:25]; m_ra = i[24:20]; m_rb = i[19:15]; m_imm = i[14:0];
      end
    end else if (m_cyc == len(m_op)) begin
      m_busy = 1'b0; m_ret++;
    end else m_cyc++;
    #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, $urandom);
  endtask
  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    @(posedge clk); #1;
    model_reset();
    cycle(1'b0, 1'b1, mk(2'b10, 7, 7, 7, 9));
    cycle(1'b1, 1'b1, mk(2'b10, 3, 1, 5, 0)); idle(4);
    cycle(1'b1, 1'b1, mk(2'b11, 4, 6, 5, 0)); idle(4);
    cycle(1'b1, 1'b1, mk(2'b00, 2, 0, 0, 1)); idle(5);
    cycle(1'b1, 1'b1, mk(2'b01, 0, 0, 2, 2)); idle(4);
    cycle(1'b1, 1'b1, mk(2'b10, 0, 3, 4, 0)); idle(4);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, k == 0 ? mk(2'b00, 9, 1, 2, 3) : $urandom);
    idle(2);
    cycle(1'b1, 1'b1, mk(2'b00, 5, 1, 0, 4));
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    idle(5);
    cycle(1'b1, 1'b1, mk(2'b01, 1, 1, 1, 1));
    cycle(1'b1, 1'b1, mk(2'b10, 1, 1, 1, 1));
    cycle(1'b1, 1'b1, mk(2'b10, 1, 1, 1, 1));
    cycle(1'b1, 1'b1, mk(2'b10, 6, 2, 3, 0));
    idle(4);
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
